// File: rtl/cache_axi_arbiter.sv
// Arbitrates I-cache and D-cache AXI read requests onto one shared AR/R port.
// One burst outstanding at a time; fixed D priority or round-robin on ties.
module cache_axi_arbiter #(
  parameter int D_PRIORITY = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] i_araddr,
  input  logic [7:0]  i_arlen,
  input  logic [1:0]  i_arburst,
  input  logic        i_arvalid,
  output logic        i_arready,
  output logic [31:0] i_rdata,
  output logic        i_rvalid,
  output logic        i_rlast,
  input  logic        i_rready,
  input  logic [31:0] d_araddr,
  input  logic [7:0]  d_arlen,
  input  logic [1:0]  d_arburst,
  input  logic        d_arvalid,
  output logic        d_arready,
  output logic [31:0] d_rdata,
  output logic        d_rvalid,
  output logic        d_rlast,
  input  logic        d_rready,
  output logic [31:0] m_araddr,
  output logic [7:0]  m_arlen,
  output logic [1:0]  m_arburst,
  output logic        m_arvalid,
  input  logic        m_arready,
  input  logic [31:0] m_rdata,
  input  logic        m_rvalid,
  input  logic        m_rlast,
  output logic        m_rready,
  output logic [1:0]  grant,
  output logic        busy,
  output logic        proto_err
);

  typedef enum logic [1:0] {
    IDLE,
    ADDR,
    DATA
  } state_t;

  state_t      state;
  logic        last_d;
  logic [7:0]  len_reg;
  logic [7:0]  beat_cnt;

  logic        gi;
  logic        gd;
  logic        in_addr;
  logic        in_data;
  logic        sel_arvalid;
  logic        pick_d;
  logic        beat;

  assign gi      = grant[0];
  assign gd      = grant[1];
  assign in_addr = (state == ADDR);
  assign in_data = (state == DATA);
  assign busy    = (state != IDLE);

  // On a tie, round-robin favours whichever port was not served last
  always_comb begin
    pick_d = d_arvalid;
    if (i_arvalid && d_arvalid) begin
      pick_d = (D_PRIORITY != 0) ? 1'b1 : !last_d;
    end
  end

  assign sel_arvalid = gd ? d_arvalid : i_arvalid;

  assign m_arvalid = in_addr & sel_arvalid;
  assign m_araddr  = !in_addr ? 32'd0 : (gd ? d_araddr : i_araddr);
  assign m_arlen   = !in_addr ? 8'd0 : (gd ? d_arlen : i_arlen);
  assign m_arburst = !in_addr ? 2'd0 : (gd ? d_arburst : i_arburst);
  assign i_arready = in_addr & gi & m_arready;
  assign d_arready = in_addr & gd & m_arready;

  assign m_rready = in_data & (gd ? d_rready : i_rready);
  assign i_rvalid = in_data & gi & m_rvalid;
  assign i_rlast  = in_data & gi & m_rlast;
  assign i_rdata  = (in_data & gi) ? m_rdata : 32'd0;
  assign d_rvalid = in_data & gd & m_rvalid;
  assign d_rlast  = in_data & gd & m_rlast;
  assign d_rdata  = (in_data & gd) ? m_rdata : 32'd0;

  assign beat = m_rvalid & m_rready;

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      grant     <= 2'b00;
      last_d    <= 1'b1;
      len_reg   <= 8'd0;
      beat_cnt  <= 8'd0;
      proto_err <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (i_arvalid || d_arvalid) begin
            grant    <= pick_d ? 2'b10 : 2'b01;
            len_reg  <= pick_d ? d_arlen : i_arlen;
            beat_cnt <= 8'd0;
            state    <= ADDR;
          end
        end
        ADDR: begin
          if (!sel_arvalid) begin
            grant <= 2'b00;
            state <= IDLE;
          end else if (m_arready) begin
            state <= DATA;
          end
        end
        DATA: begin
          if (beat) begin
            beat_cnt <= beat_cnt + 8'd1;
            if (m_rlast != (beat_cnt == len_reg)) begin
              proto_err <= 1'b1;
            end
            if (m_rlast) begin
              last_d <= grant[1];
              grant  <= 2'b00;
              state  <= IDLE;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
